// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Moore micro-sequencer for the single-bus datapath. Runs the
//             fetch (T0-T2), decode (T3) and execute (T4-T6) steps and drives
//             the datapath strobes, the one-hot register selects and alu_op.
//             Fetch uses a mem_ready handshake with a bounded wait.
//  Config   : `define MULDIV_EN enables mul/div (opcodes 16/17, step T6).
//             Without it, 16/17 are illegal and hi_in/zhigh_out are tied 0.
//  Ports    : clock      - rising-edge clock
//             clear      - asynchronous active-low reset
//             run        - level; fetch while high, checked at boundaries
//             mem_ready  - memory data valid on Mdatain
//             ir[31:0]   - IR contents {opcode, ra, rb, rc, ...}
//             reg_out    - one-hot R0..R15 bus-out selects
//             reg_in     - one-hot R0..R15 load strobes
//             pc_out .. read - single-bit datapath strobes
//             alu_op     - ALU opcode
//             halted     - in HALT
//             fault      - in FAULT
//             instr_cnt  - retired-instruction count (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module control_sequencer #(
  parameter int         WAIT_MAX = 16,
  parameter logic [4:0] ALU_ADD  = 5'd3,
  parameter logic [4:0] ALU_AND  = 5'd5,
  parameter logic [4:0] ALU_OR   = 5'd6
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        pc_out,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic        c_out,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_cnt
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  // Registered control word. Register selects are stored as "which field"
  // flags and expanded from the live ir fields, which are stable T3-T6.
  typedef struct packed {
    logic       pc_out;
    logic       pc_in_arm;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       zlow_out;
`ifdef MULDIV_EN
    logic       zhigh_out;
    logic       hi_in;
`endif
    logic       lo_in;
    logic       c_out;
    logic       inc_pc;
    logic       read;
    logic       sel_rb;
    logic       sel_rc;
    logic       sel_ra;
    logic       alu_from_op;
    logic [4:0] alu_fix;
    logic       halted;
    logic       fault;
  } ctl_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_boundary;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [15:0]       r_instr_cnt;
  logic              w_retire;
  ctl_t              r_ctl;
  ctl_t              w_ctl_nxt;

  // Live instruction field decode
  logic [4:0] w_opcode;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_is_rtype;
  logic       w_is_itype;
  logic       w_is_muldiv;
  logic       w_is_negnot;
  logic       w_is_nop;
  logic       w_is_halt;
  logic       w_legal;
  logic [4:0] w_itype_op;
  logic       unused_ir_low;

  assign w_opcode      = ir[31:27];
  assign w_ra          = ir[26:23];
  assign w_rb          = ir[22:19];
  assign w_rc          = ir[18:15];
  assign unused_ir_low = ^ir[14:0];

  assign w_is_rtype  = (w_opcode <= 5'd12);
  assign w_is_itype  = (w_opcode >= 5'd13) && (w_opcode <= 5'd15);
`ifdef MULDIV_EN
  assign w_is_muldiv = (w_opcode == 5'd16) || (w_opcode == 5'd17);
`else
  assign w_is_muldiv = 1'b0;
`endif
  assign w_is_negnot = (w_opcode == 5'd18) || (w_opcode == 5'd19);
  assign w_is_nop    = (w_opcode == 5'd26);
  assign w_is_halt   = (w_opcode == 5'd27);
  assign w_legal     = w_is_rtype | w_is_itype | w_is_muldiv | w_is_negnot |
                       w_is_nop | w_is_halt;

  always_comb begin
    case (w_opcode)
      5'd13:   w_itype_op = ALU_ADD;
      5'd14:   w_itype_op = ALU_AND;
      default: w_itype_op = ALU_OR;
    endcase
  end

  // Where an instruction goes once it retires: run is only looked at here.
  assign w_boundary = run ? S_T0 : S_IDLE;

  // Next-state and retire decode
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_state_nxt = S_T0;
      S_T0:   w_state_nxt = S_T1;
      S_T1: begin
        if (mem_ready) begin
          w_state_nxt = S_T2;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          if (r_wait_cnt == WAIT_W'(WAIT_MAX - 1)) w_state_nxt = S_FAULT;
        end
      end
      S_T2:   w_state_nxt = S_T3;
      S_T3: begin
        if (!w_legal) begin
          w_state_nxt = S_FAULT;
        end else if (w_is_nop) begin
          w_state_nxt = w_boundary;
          w_retire    = 1'b1;
        end else if (w_is_halt) begin
          w_state_nxt = S_HALT;
          w_retire    = 1'b1;
        end else begin
          w_state_nxt = S_T4;
        end
      end
      S_T4:   w_state_nxt = S_T5;
      S_T5: begin
        if (w_is_muldiv) begin
          w_state_nxt = S_T6;
        end else begin
          w_state_nxt = w_boundary;
          w_retire    = 1'b1;
        end
      end
`ifdef MULDIV_EN
      S_T6: begin
        w_state_nxt = w_boundary;
        w_retire    = 1'b1;
      end
`endif
      S_HALT:  w_state_nxt = S_HALT;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FAULT;
    endcase
  end

  // Control word for the state being entered, so the registered outputs
  // line up with the state register.
  always_comb begin
    w_ctl_nxt = '0;
    case (w_state_nxt)
      S_T0: begin
        w_ctl_nxt.pc_out  = 1'b1;
        w_ctl_nxt.mar_in  = 1'b1;
        w_ctl_nxt.inc_pc  = 1'b1;
        w_ctl_nxt.z_in    = 1'b1;
        w_ctl_nxt.alu_fix = ALU_ADD;
      end
      S_T1: begin
        w_ctl_nxt.zlow_out  = 1'b1;
        w_ctl_nxt.pc_in_arm = 1'b1;
        w_ctl_nxt.read      = 1'b1;
        w_ctl_nxt.mdr_in    = 1'b1;
      end
      S_T2: begin
        w_ctl_nxt.mdr_out = 1'b1;
        w_ctl_nxt.ir_in   = 1'b1;
      end
      S_T3: begin
        w_ctl_nxt.sel_rb = 1'b1;
        w_ctl_nxt.y_in   = 1'b1;
      end
      S_T4: begin
        w_ctl_nxt.z_in = 1'b1;
        if (w_is_itype) begin
          w_ctl_nxt.c_out   = 1'b1;
          w_ctl_nxt.alu_fix = w_itype_op;
        end else if (w_is_negnot) begin
          w_ctl_nxt.sel_rb      = 1'b1;
          w_ctl_nxt.alu_from_op = 1'b1;
        end else begin
          w_ctl_nxt.sel_rc      = 1'b1;
          w_ctl_nxt.alu_from_op = 1'b1;
        end
      end
      S_T5: begin
        w_ctl_nxt.zlow_out = 1'b1;
        if (w_is_muldiv) w_ctl_nxt.lo_in  = 1'b1;
        else             w_ctl_nxt.sel_ra = 1'b1;
      end
`ifdef MULDIV_EN
      S_T6: begin
        w_ctl_nxt.zhigh_out = 1'b1;
        w_ctl_nxt.hi_in     = 1'b1;
      end
`endif
      S_HALT:  w_ctl_nxt.halted = 1'b1;
      S_FAULT: w_ctl_nxt.fault  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_instr_cnt <= '0;
      r_ctl       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_ctl      <= w_ctl_nxt;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  // sel_rb and sel_rc are never set together, so reg_out stays one-hot.
  assign reg_out = r_ctl.sel_rb ? (16'h0001 << w_rb) :
                   r_ctl.sel_rc ? (16'h0001 << w_rc) : 16'h0000;
  assign reg_in  = r_ctl.sel_ra ? (16'h0001 << w_ra) : 16'h0000;
  assign alu_op  = r_ctl.alu_from_op ? w_opcode : r_ctl.alu_fix;

  // PC loads once: only in the T1 cycle that actually sees the data.
  assign pc_in     = r_ctl.pc_in_arm & mem_ready;
  assign pc_out    = r_ctl.pc_out;
  assign mar_in    = r_ctl.mar_in;
  assign mdr_in    = r_ctl.mdr_in;
  assign mdr_out   = r_ctl.mdr_out;
  assign ir_in     = r_ctl.ir_in;
  assign y_in      = r_ctl.y_in;
  assign z_in      = r_ctl.z_in;
  assign zlow_out  = r_ctl.zlow_out;
`ifdef MULDIV_EN
  assign zhigh_out = r_ctl.zhigh_out;
  assign hi_in     = r_ctl.hi_in;
`else
  assign zhigh_out = 1'b0;
  assign hi_in     = 1'b0;
`endif
  assign lo_in     = r_ctl.lo_in;
  assign c_out     = r_ctl.c_out;
  assign inc_pc    = r_ctl.inc_pc;
  assign read      = r_ctl.read;
  assign halted    = r_ctl.halted;
  assign fault     = r_ctl.fault;
  assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire
